wb_regfile_mp: RTL

- Parametrised multi-lane writeback stage with integrated register file and scoreboard for the superscalar core.
- Each cycle it accepts up to NUM_WB retiring results, selects load or ALU data per lane, and commits them to the register file.
- Provides NUM_RD bypassed read ports and per-register busy bits to the issue stage.
- Sits between the memory/ALU stages and issue/decode.

---
 rtl/wb_pkg.sv | 29 ++
 rtl/wb_lane_sel.sv | 36 +++
 rtl/wb_regfile_mp.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback / register-file block.
// Holds default widths, the lane-slice offset helper used to address packed
// per-lane buses, and a popcount used for the retire counter.
package wb_pkg;

  localparam int unsigned DefDataW   = 16;
  localparam int unsigned DefNumRegs = 8;
  localparam int unsigned DefRegAw   = 3;
  localparam int unsigned DefNumWb   = 2;
  localparam int unsigned DefNumRd   = 4;

  // Width of the popcount input; callers zero-extend narrower vectors.
  localparam int unsigned PopW = 32;

  // LSB of lane `lane` inside a packed bus of `width`-bit lanes.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

  function automatic logic [31:0] popcount(input logic [PopW-1:0] v);
    logic [31:0] c;
    c = '0;
    for (int unsigned k = 0; k < PopW; k++) begin
      c = c + 32'(v[k]);
    end
    return c;
  endfunction

endpackage

// File: rtl/wb_lane_sel.sv
// One writeback lane: picks load or ALU data as the lane result and decodes
// the destination register into a one-hot write-enable (all zero when the
// lane is not valid).
// Ports:
//   valid_i   lane writeback request
//   isld_i    1 selects ld_i, 0 selects alu_i
//   rd_i      destination register index
//   ld_i      load data
//   alu_i     ALU data
//   result_o  selected lane result
//   wr_oh_o   one-hot write enable per register, gated by valid_i
module wb_lane_sel
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned NUM_REGS = DefNumRegs,
  parameter int unsigned REG_AW   = DefRegAw
) (
  input  logic                valid_i,
  input  logic                isld_i,
  input  logic [REG_AW-1:0]   rd_i,
  input  logic [DATA_W-1:0]   ld_i,
  input  logic [DATA_W-1:0]   alu_i,
  output logic [DATA_W-1:0]   result_o,
  output logic [NUM_REGS-1:0] wr_oh_o
);

  always_comb begin
    result_o = isld_i ? ld_i : alu_i;
    wr_oh_o  = '0;
    if (valid_i) begin
      wr_oh_o[rd_i] = 1'b1;
    end
  end

endmodule

// File: rtl/wb_regfile_mp.sv
// Multi-lane writeback stage with register file, bypassed read ports and a
// busy-bit scoreboard for the issue stage.
// Ports:
//   clk, rst_n     clock and synchronous active-low reset
//   wb_valid       per-lane writeback request
//   wb_isld        per-lane load/ALU select
//   wb_rd          per-lane destination (packed, REG_AW bits per lane)
//   wb_ldresult    per-lane load data
//   wb_aluresult   per-lane ALU data
//   iss_valid      per-lane issue, marks iss_rd busy
//   iss_rd         per-lane issued destination
//   rd_addr        read addresses (packed, NUM_RD ports)
//   rd_data        read data, combinational, bypassed from this cycle's lanes
//   busy           scoreboard, bit r set while a write to r is pending
//   wb_result      registered per-lane result (holds when lane idle)
//   wb_commit      registered per-lane commit flag
//   retire_cnt     registered wrapping count of committed writes
module wb_regfile_mp
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned NUM_REGS = DefNumRegs,
  parameter int unsigned REG_AW   = DefRegAw,
  parameter int unsigned NUM_WB   = DefNumWb,
  parameter int unsigned NUM_RD   = DefNumRd,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB-1:0]          wb_isld,
  input  logic [NUM_WB*REG_AW-1:0]   wb_rd,
  input  logic [NUM_WB*DATA_W-1:0]   wb_ldresult,
  input  logic [NUM_WB*DATA_W-1:0]   wb_aluresult,
  input  logic [NUM_WB-1:0]          iss_valid,
  input  logic [NUM_WB*REG_AW-1:0]   iss_rd,
  input  logic [NUM_RD*REG_AW-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_REGS-1:0]        busy,
  output logic [NUM_WB*DATA_W-1:0]   wb_result,
  output logic [NUM_WB-1:0]          wb_commit,
  output logic [31:0]                retire_cnt
);

  logic [DATA_W-1:0]        lane_res [NUM_WB];
  logic [NUM_REGS-1:0]      lane_oh  [NUM_WB];

  logic [DATA_W-1:0]        regs_q [NUM_REGS];
  logic [DATA_W-1:0]        regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]      busy_q, busy_d;
  logic [NUM_WB*DATA_W-1:0] wb_result_q, wb_result_d;
  logic [NUM_WB-1:0]        wb_commit_q;
  logic [31:0]              retire_cnt_q, retire_cnt_d;

  for (genvar i = 0; i < NUM_WB; i++) begin : g_lane
    wb_lane_sel #(
      .DATA_W  (DATA_W),
      .NUM_REGS(NUM_REGS),
      .REG_AW  (REG_AW)
    ) u_lane_sel (
      .valid_i (wb_valid[i]),
      .isld_i  (wb_isld[i]),
      .rd_i    (wb_rd[lane_lsb(i, REG_AW) +: REG_AW]),
      .ld_i    (wb_ldresult[lane_lsb(i, DATA_W) +: DATA_W]),
      .alu_i   (wb_aluresult[lane_lsb(i, DATA_W) +: DATA_W]),
      .result_o(lane_res[i]),
      .wr_oh_o (lane_oh[i])
    );
  end

  // Lanes applied in ascending order so the highest-index lane wins a shared rd.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      regs_d[r] = regs_q[r];
    end
    for (int i = 0; i < NUM_WB; i++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (lane_oh[i][r]) begin
          regs_d[r] = lane_res[i];
        end
      end
    end
    if (ZERO_REG) begin
      regs_d[0] = '0;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [REG_AW-1:0] raddr;
    logic [DATA_W-1:0] rval;

    assign raddr = rd_addr[lane_lsb(p, REG_AW) +: REG_AW];

    always_comb begin
      rval = regs_q[raddr];
      for (int i = 0; i < NUM_WB; i++) begin
        if (lane_oh[i][raddr]) begin
          rval = lane_res[i];
        end
      end
      if (ZERO_REG && (raddr == '0)) begin
        rval = '0;
      end
    end

    assign rd_data[lane_lsb(p, DATA_W) +: DATA_W] = rval;
  end

  // Clears first, then sets: a new issue to a retiring rd keeps it busy.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_WB; i++) begin
      busy_d = busy_d & ~lane_oh[i];
    end
    for (int i = 0; i < NUM_WB; i++) begin
      if (iss_valid[i]) begin
        busy_d[iss_rd[i*REG_AW +: REG_AW]] = 1'b1;
      end
    end
    if (ZERO_REG) begin
      busy_d[0] = 1'b0;
    end
  end

  always_comb begin
    wb_result_d = wb_result_q;
    for (int i = 0; i < NUM_WB; i++) begin
      if (wb_valid[i]) begin
        wb_result_d[i*DATA_W +: DATA_W] = lane_res[i];
      end
    end
    retire_cnt_d = retire_cnt_q + popcount(PopW'(wb_valid));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q       <= '0;
      wb_result_q  <= '0;
      wb_commit_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
      busy_q       <= busy_d;
      wb_result_q  <= wb_result_d;
      wb_commit_q  <= wb_valid;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign busy       = busy_q;
  assign wb_result  = wb_result_q;
  assign wb_commit  = wb_commit_q;
  assign retire_cnt = retire_cnt_q;

endmodule
